// File: rtl/addr_gen.sv
// Address and RAM-control generator for a constant-geometry NTT over two ping-pong RAM pairs.
// One butterfly read per valid cycle; the matching two-word write emerges PIPE cycles later.
module addr_gen #(
    parameter int ADDRWIDTH = 8,
    parameter int STAGES    = ADDRWIDTH + 1,
    parameter int PIPE      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 valid,
    output logic [ADDRWIDTH-1:0] i,
    output logic [4:0]           stage,
    output logic                 en,
    output logic                 ram0_ena,
    output logic                 ram0_enb,
    output logic                 ram0_wea,
    output logic                 ram0_web,
    output logic                 ram1_ena,
    output logic                 ram1_enb,
    output logic                 ram1_wea,
    output logic                 ram1_web,
    output logic                 ram2_ena,
    output logic                 ram2_enb,
    output logic                 ram2_wea,
    output logic                 ram2_web,
    output logic                 ram3_ena,
    output logic                 ram3_enb,
    output logic                 ram3_wea,
    output logic                 ram3_web,
    output logic                 ram_flag_w,
    output logic                 stage_flag_w,
    output logic                 stage_flag_r,
    output logic [ADDRWIDTH-1:0] w_addr_0,
    output logic [ADDRWIDTH-1:0] w_addr_1,
    output logic [ADDRWIDTH-1:0] r_addr_0,
    output logic [ADDRWIDTH-1:0] r_addr_1
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int                   CW        = (PIPE > 1) ? $clog2(PIPE) : 1;
    localparam logic [CW-1:0]        CNT_LAST  = CW'(PIPE - 1);
    localparam logic [4:0]           STG_LAST  = 5'(STAGES - 1);
    localparam logic [ADDRWIDTH-1:0] I_LAST    = '1;

    logic [1:0]           r_state;
    logic [ADDRWIDTH-1:0] r_i;
    logic [4:0]           r_stage;
    logic [CW-1:0]        r_cnt;

    logic                 r_sr_v [PIPE];
    logic [ADDRWIDTH-1:0] r_sr_i [PIPE];
    logic                 r_sr_s [PIPE];

    logic                 w_en;
    logic                 w_wv;
    logic [ADDRWIDTH-1:0] w_iw;
    logic                 w_sw;
    logic                 w_rd_lo;
    logic                 w_rd_hi;
    logic                 w_wr0;
    logic                 w_wr1;
    logic                 w_wr2;
    logic                 w_wr3;

    assign w_en = (r_state == S_READ) & valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_stage <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_READ;
                end
                S_READ: begin
                    if (valid) begin
                        r_i <= r_i + 1'b1;
                        if (r_i == I_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Hold off the next stage until every write of this one has landed.
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (r_stage == STG_LAST) begin
                            r_stage <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_stage <= r_stage + 1'b1;
                            r_state <= S_READ;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Write-side delay line: runs every cycle so stalls on valid never delay in-flight writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int p = 0; p < PIPE; p++) begin
                r_sr_v[p] <= 1'b0;
                r_sr_i[p] <= '0;
                r_sr_s[p] <= 1'b0;
            end
        end else begin
            r_sr_v[0] <= w_en;
            r_sr_i[0] <= r_i;
            r_sr_s[0] <= r_stage[0];
            for (int p = 1; p < PIPE; p++) begin
                r_sr_v[p] <= r_sr_v[p-1];
                r_sr_i[p] <= r_sr_i[p-1];
                r_sr_s[p] <= r_sr_s[p-1];
            end
        end
    end

    assign w_wv = r_sr_v[PIPE-1];
    assign w_iw = r_sr_i[PIPE-1];
    assign w_sw = r_sr_s[PIPE-1];

    assign w_rd_lo = w_en & ~r_stage[0];
    assign w_rd_hi = w_en &  r_stage[0];

    // Even stages read RAM0/1 and write RAM2/3; odd stages swap.
    assign w_wr0 = w_wv &  w_sw & ~w_iw[ADDRWIDTH-1];
    assign w_wr1 = w_wv &  w_sw &  w_iw[ADDRWIDTH-1];
    assign w_wr2 = w_wv & ~w_sw & ~w_iw[ADDRWIDTH-1];
    assign w_wr3 = w_wv & ~w_sw &  w_iw[ADDRWIDTH-1];

    assign ram0_ena = w_rd_lo | w_wr0;
    assign ram1_ena = w_rd_lo | w_wr1;
    assign ram2_ena = w_rd_hi | w_wr2;
    assign ram3_ena = w_rd_hi | w_wr3;
    assign ram0_enb = w_wr0;
    assign ram1_enb = w_wr1;
    assign ram2_enb = w_wr2;
    assign ram3_enb = w_wr3;
    assign ram0_wea = w_wr0;
    assign ram1_wea = w_wr1;
    assign ram2_wea = w_wr2;
    assign ram3_wea = w_wr3;
    assign ram0_web = w_wr0;
    assign ram1_web = w_wr1;
    assign ram2_web = w_wr2;
    assign ram3_web = w_wr3;

    assign i            = r_i;
    assign stage        = r_stage;
    assign en           = w_en;
    assign stage_flag_r = r_stage[0];
    assign r_addr_0     = r_i;
    assign r_addr_1     = r_i;

    // Write-side flags and addresses are held at 0 while no write is in flight.
    assign stage_flag_w = w_wv & ~w_sw;
    assign ram_flag_w   = w_wv & w_iw[ADDRWIDTH-1];
    assign w_addr_0     = w_wv ? {w_iw[ADDRWIDTH-2:0], 1'b0} : '0;
    assign w_addr_1     = w_wv ? {w_iw[ADDRWIDTH-2:0], 1'b1} : '0;

endmodule

// File: tb/tb_addr_gen.sv
// Directed bench for addr_gen: read side checked cycle by cycle, writes via a due-cycle scoreboard.
module tb_addr_gen;

    localparam int AW     = 3;
    localparam int STAGES = 4;
    localparam int PIPE   = 4;
    localparam int B      = 8;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic valid;

    logic [AW-1:0] i;
    logic [4:0]    stage;
    logic          en;
    logic ram0_ena, ram0_enb, ram0_wea, ram0_web;
    logic ram1_ena, ram1_enb, ram1_wea, ram1_web;
    logic ram2_ena, ram2_enb, ram2_wea, ram2_web;
    logic ram3_ena, ram3_enb, ram3_wea, ram3_web;
    logic ram_flag_w, stage_flag_w, stage_flag_r;
    logic [AW-1:0] w_addr_0, w_addr_1, r_addr_0, r_addr_1;

    logic [3:0] ena_v, enb_v, wea_v, web_v;
    assign ena_v = {ram3_ena, ram2_ena, ram1_ena, ram0_ena};
    assign enb_v = {ram3_enb, ram2_enb, ram1_enb, ram0_enb};
    assign wea_v = {ram3_wea, ram2_wea, ram1_wea, ram0_wea};
    assign web_v = {ram3_web, ram2_web, ram1_web, ram0_web};

    addr_gen #(.ADDRWIDTH(AW), .STAGES(STAGES), .PIPE(PIPE)) dut (
        .clk(clk), .reset(reset), .start(start), .valid(valid),
        .i(i), .stage(stage), .en(en),
        .ram0_ena(ram0_ena), .ram0_enb(ram0_enb), .ram0_wea(ram0_wea), .ram0_web(ram0_web),
        .ram1_ena(ram1_ena), .ram1_enb(ram1_enb), .ram1_wea(ram1_wea), .ram1_web(ram1_web),
        .ram2_ena(ram2_ena), .ram2_enb(ram2_enb), .ram2_wea(ram2_wea), .ram2_web(ram2_web),
        .ram3_ena(ram3_ena), .ram3_enb(ram3_enb), .ram3_wea(ram3_wea), .ram3_web(ram3_web),
        .ram_flag_w(ram_flag_w), .stage_flag_w(stage_flag_w), .stage_flag_r(stage_flag_r),
        .w_addr_0(w_addr_0), .w_addr_1(w_addr_1), .r_addr_0(r_addr_0), .r_addr_1(r_addr_1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int idx;
        int sw;
    } wr_t;

    wr_t sb[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset_step(input logic st, input logic v);
        reset = 1'b0;
        start = st;
        valid = v;
        #1;
        chk("rst_ctrl", 32'({en, i, stage, stage_flag_r, stage_flag_w, ram_flag_w}), 32'd0);
        chk("rst_en", 32'({ena_v, enb_v, wea_v, web_v}), 32'd0);
        chk("rst_addr", 32'({w_addr_0, w_addr_1, r_addr_0, r_addr_1}), 32'd0);
        tick();
    endtask

    // One normal cycle: check the read side now, queue the write it implies, check any write due now.
    task automatic cyc_step(input logic v, input logic st, input logic exp_en,
                            input int exp_i, input int exp_stg);
        logic [3:0] e_ena;
        logic [3:0] e_wr;
        wr_t        w;
        wr_t        n;
        int         ram;
        reset = 1'b1;
        start = st;
        valid = v;
        #1;
        chk("en", 32'(en), 32'(exp_en));
        chk("i", 32'(i), 32'(exp_i));
        chk("stage", 32'(stage), 32'(exp_stg));
        chk("r_addr", 32'({r_addr_0, r_addr_1}), 32'({exp_i[AW-1:0], exp_i[AW-1:0]}));
        chk("stage_flag_r", 32'(stage_flag_r), 32'(exp_stg % 2));
        if (exp_en) begin
            n.due = cyc + PIPE;
            n.idx = exp_i;
            n.sw  = exp_stg % 2;
            sb.push_back(n);
        end
        e_ena = exp_en ? ((exp_stg % 2 == 1) ? 4'b1100 : 4'b0011) : 4'b0000;
        e_wr  = 4'b0000;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            w   = sb.pop_front();
            ram = ((w.sw == 1) ? 0 : 2) + ((w.idx >= B / 2) ? 1 : 0);
            e_wr = 4'(1 << ram);
            chk("stage_flag_w", 32'(stage_flag_w), 32'((w.sw == 1) ? 0 : 1));
            chk("ram_flag_w", 32'(ram_flag_w), 32'(w.idx / (B / 2)));
            chk("w_addr_0", 32'(w_addr_0), 32'((w.idx % (B / 2)) * 2));
            chk("w_addr_1", 32'(w_addr_1), 32'((w.idx % (B / 2)) * 2 + 1));
        end
        chk("ena", 32'(ena_v), 32'(e_ena | e_wr));
        chk("enb", 32'(enb_v), 32'(e_wr));
        chk("wea", 32'(wea_v), 32'(e_wr));
        chk("web", 32'(web_v), 32'(e_wr));
        tick();
    endtask

    // B reads (optionally with a stall cycle between each) followed by PIPE drain cycles.
    task automatic run_stage(input int s, input bit toggle, input logic st);
        for (int k = 0; k < B; k++) begin
            cyc_step(1'b1, st, 1'b1, k, s);
            if (toggle && k < B - 1) cyc_step(1'b0, st, 1'b0, k + 1, s);
        end
        for (int d = 0; d < PIPE; d++) cyc_step(1'b1, st, 1'b0, 0, s);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b1;
        valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        repeat (3) reset_step(1'b1, 1'b1);
        // First cycle after release is still IDLE.
        cyc_step(1'b1, 1'b1, 1'b0, 0, 0);

        run_stage(0, 1'b0, 1'b1);
        run_stage(1, 1'b1, 1'b1);
        run_stage(2, 1'b0, 1'b1);
        run_stage(3, 1'b0, 1'b1);
        cyc_step(1'b1, 1'b1, 1'b0, 0, 0);

        // Restart with start held high: exactly STAGES*(B+PIPE) cycles, then IDLE.
        for (int s = 0; s < STAGES; s++) run_stage(s, 1'b0, 1'b1);
        cyc_step(1'b1, 1'b1, 1'b0, 0, 0);

        run_stage(0, 1'b0, 1'b1);
        run_stage(1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) cyc_step(1'b1, 1'b1, 1'b1, k, 2);

        // Abort mid stage 2: queued writes must never appear.
        reset = 1'b0;
        start = 1'b1;
        valid = 1'b0;
        tick();
        sb.delete();
        reset_step(1'b1, 1'b1);
        reset_step(1'b0, 1'b1);
        repeat (8) cyc_step(1'b1, 1'b0, 1'b0, 0, 0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
